// File: rtl/siphash_msg_sequencer_pkg.sv
// siphash_msg_sequencer_pkg: SipHash IV constants, FSM encoding and round defaults
package siphash_msg_sequencer_pkg;
  localparam logic [63:0] IV0 = 64'h736f6d6570736575;
  localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
  localparam logic [63:0] IV2 = 64'h6c7967656e657261;
  localparam logic [63:0] IV3 = 64'h7465646279746573;
  localparam logic [3:0] C_ROUNDS_DEF = 4'd2;
  localparam logic [3:0] D_ROUNDS_DEF = 4'd4;
  localparam logic [3:0] BLK_BYTES = 4'd8;
  typedef enum logic [2:0] {IDLE, INIT, ACCEPT, COMP, WAIT_C, FIN, WAIT_F} state_t;
  function automatic logic [255:0] derive_key(input logic [127:0] key);
    return {key[127:64] ^ IV3, key[63:0] ^ IV2, key[127:64] ^ IV1, key[63:0] ^ IV0};
  endfunction
endpackage

// File: rtl/siphash_pad.sv
// siphash_pad: builds the SipHash final block from the partial last beat and total length
module siphash_pad
  import siphash_msg_sequencer_pkg::*;
(
  input  logic [55:0] data,
  input  logic [3:0]  nbytes,
  input  logic [7:0]  len,
  output logic [63:0] tail
);
  // Keep bytes below nbytes, zero the rest; a full beat contributes only the length byte.
  always_comb begin
    tail = {len, 56'h0};
    for (int i = 0; i < 7; i++)
      if (nbytes < BLK_BYTES && 4'(i) < nbytes) tail[8*i +: 8] = data[8*i +: 8];
  end
endmodule

// File: rtl/siphash_msg_sequencer.sv
// siphash_msg_sequencer: feeds message beats into a SipHash core and collects the digest
module siphash_msg_sequencer
  import siphash_msg_sequencer_pkg::*;
#(
  parameter logic [3:0] C_ROUNDS = C_ROUNDS_DEF,
  parameter logic [3:0] D_ROUNDS = D_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [3:0]   in_nbytes,
  input  logic         in_last,
  output logic         busy,
  output logic [63:0]  digest,
  output logic         digest_valid,
  output logic         core_initalize,
  output logic         core_compress,
  output logic         core_finalize,
  output logic [3:0]   core_compression_rounds,
  output logic [3:0]   core_final_rounds,
  output logic [255:0] core_key,
  output logic [63:0]  core_nonce,
  input  logic         core_ready,
  input  logic [63:0]  core_word,
  input  logic         core_word_valid
);
  state_t      state;
  logic [7:0]  len;
  logic        last_blk;
  logic        tail_pend;
  logic [3:0]  nb;
  logic [7:0]  len_last;
  logic [63:0] tail;

  assign core_compression_rounds = C_ROUNDS;
  assign core_final_rounds = D_ROUNDS;
  assign nb = in_nbytes > BLK_BYTES ? BLK_BYTES : in_nbytes;
  assign len_last = len + {4'd0, nb};

  siphash_pad u_pad (
    .data   (in_data[55:0]),
    .nbytes (nb),
    .len    (len_last),
    .tail   (tail)
  );

  // Command sequencer; wait states ignore core_ready while their own command pulse is still out,
  // since the core's ready only drops one cycle after it sees a command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      in_ready       <= 1'b0;
      digest         <= 64'h0;
      digest_valid   <= 1'b0;
      core_initalize <= 1'b0;
      core_compress  <= 1'b0;
      core_finalize  <= 1'b0;
      core_key       <= 256'h0;
      core_nonce     <= 64'h0;
      len            <= 8'h0;
      last_blk       <= 1'b0;
      tail_pend      <= 1'b0;
    end else begin
      core_initalize <= 1'b0;
      core_compress  <= 1'b0;
      core_finalize  <= 1'b0;
      digest_valid   <= 1'b0;
      if (digest_valid) busy <= 1'b0;
      case (state)
        IDLE: if (start && !busy) begin
          core_key <= derive_key(key);
          len      <= 8'h0;
          busy     <= 1'b1;
          state    <= INIT;
        end
        INIT: if (core_ready) begin
          core_initalize <= 1'b1;
          in_ready       <= 1'b1;
          state          <= ACCEPT;
        end
        ACCEPT: if (in_valid && in_ready) begin
          in_ready <= 1'b0;
          state    <= COMP;
          if (!in_last) begin
            core_nonce <= in_data;
            len        <= len + 8'd8;
            last_blk   <= 1'b0;
            tail_pend  <= 1'b0;
          end else if (nb == BLK_BYTES) begin
            core_nonce <= in_data;
            len        <= len_last;
            last_blk   <= 1'b0;
            tail_pend  <= 1'b1;
          end else begin
            core_nonce <= tail;
            len        <= len_last;
            last_blk   <= 1'b1;
            tail_pend  <= 1'b0;
          end
        end
        COMP: if (core_ready) begin
          core_compress <= 1'b1;
          state         <= WAIT_C;
        end
        WAIT_C: if (core_ready && !core_compress) begin
          if (last_blk) state <= FIN;
          else if (tail_pend) begin
            core_nonce <= {len, 56'h0};
            tail_pend  <= 1'b0;
            last_blk   <= 1'b1;
            state      <= COMP;
          end else begin
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        FIN: if (core_ready) begin
          core_finalize <= 1'b1;
          state         <= WAIT_F;
        end
        WAIT_F: if (core_ready && core_word_valid && !core_finalize) begin
          digest       <= core_word;
          digest_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_siphash_msg_sequencer.sv
// tb_siphash_msg_sequencer: scoreboard bench with a behavioural SipHash core model
module tb_siphash_msg_sequencer;
  localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [63:0] DIG_EMPTY = 64'h726fdb47dd0e0e31;
  localparam logic [63:0] DIG_15 = 64'ha129ca6149be45e5;
  localparam logic [63:0] DIG_8 = 64'h93f5f5799a932462;
  localparam logic [63:0] V0_INIT = 64'h0706050403020100 ^ 64'h736f6d6570736575;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic [3:0]   in_nbytes = '0;
  logic         in_last = 1'b0;
  logic         busy;
  logic [63:0]  digest;
  logic         digest_valid;
  logic         core_initalize, core_compress, core_finalize;
  logic [3:0]   core_compression_rounds, core_final_rounds;
  logic [255:0] core_key;
  logic [63:0]  core_nonce;
  logic         core_ready;
  logic [63:0]  core_word;
  logic         core_word_valid;

  int total = 0;
  int passed = 0;
  logic [63:0] exp_dig[$];
  logic [63:0] exp_nonce[$];
  int unsigned stall_max = 0;
  int unsigned stall;
  logic [255:0] ms;
  logic pend;
  int fin_cnt;
  logic rdy_prev, cmd_prev, hs_prev;

  siphash_msg_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
    .busy(busy), .digest(digest), .digest_valid(digest_valid),
    .core_initalize(core_initalize), .core_compress(core_compress), .core_finalize(core_finalize),
    .core_compression_rounds(core_compression_rounds), .core_final_rounds(core_final_rounds),
    .core_key(core_key), .core_nonce(core_nonce),
    .core_ready(core_ready), .core_word(core_word), .core_word_valid(core_word_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
    return (x << s) | (x >> (64 - s));
  endfunction

  function automatic logic [255:0] sip_rounds(input logic [255:0] s, input logic [3:0] n);
    logic [63:0] v0, v1, v2, v3;
    {v3, v2, v1, v0} = s;
    for (int r = 0; r < int'(n); r++) begin
      v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
      v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
      v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
      v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
    end
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [255:0] absorb(input logic [255:0] s, input logic [63:0] m, input logic [3:0] n);
    logic [255:0] t;
    t = sip_rounds(s ^ {m, 192'h0}, n);
    return t ^ {192'h0, m};
  endfunction

  function automatic logic [63:0] squeeze(input logic [255:0] s, input logic [3:0] n);
    logic [255:0] t;
    t = sip_rounds(s ^ {64'h0, 64'hff, 128'h0}, n);
    return t[63:0] ^ t[127:64] ^ t[191:128] ^ t[255:192];
  endfunction

  // Core model: ready drops the cycle after any command and returns after a random stall
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b1;
      core_word_valid <= 1'b0;
      core_word <= '0;
      stall <= 0;
      pend <= 1'b0;
      ms <= '0;
    end else begin
      if (core_initalize || core_compress || core_finalize) begin
        core_ready <= 1'b0;
        stall <= $urandom_range(stall_max, 0);
      end else if (!core_ready) begin
        if (stall > 0) stall <= stall - 1;
        else begin
          core_ready <= 1'b1;
          if (pend) begin
            core_word_valid <= 1'b1;
            pend <= 1'b0;
          end
        end
      end
      if (core_initalize) begin
        ms <= core_key;
        core_word_valid <= 1'b0;
      end
      if (core_compress) ms <= absorb(ms, core_nonce, core_compression_rounds);
      if (core_finalize) begin
        core_word <= squeeze(ms, core_final_rounds);
        core_word_valid <= 1'b0;
        pend <= 1'b1;
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pops on compress and on digest
  always @(negedge clk) begin
    if (!reset_n) begin
      fin_cnt = 0;
      rdy_prev = 1'b1;
      cmd_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (core_initalize || core_compress || core_finalize) begin
        check("cmd_while_core_not_ready", {63'd0, !rdy_prev}, 64'd0);
        check("cmd_back_to_back", {63'd0, cmd_prev}, 64'd0);
      end
      if (hs_prev) check("in_ready_after_beat", {63'd0, in_ready}, 64'd0);
      if (core_compress || core_finalize) check("in_ready_during_cmd", {63'd0, in_ready}, 64'd0);
      if (core_compress) begin
        check("compress_expected", 64'(exp_nonce.size() != 0), 64'd1);
        if (exp_nonce.size() != 0) check("core_nonce", core_nonce, exp_nonce.pop_front());
      end
      if (core_finalize) fin_cnt++;
      if (digest_valid) begin
        check("digest_expected", 64'(exp_dig.size() != 0), 64'd1);
        if (exp_dig.size() != 0) check("digest", digest, exp_dig.pop_front());
        check("compress_count_left", 64'(exp_nonce.size()), 64'd0);
        check("finalize_count", 64'(fin_cnt), 64'd1);
        check("busy_at_digest", {63'd0, busy}, 64'd1);
        fin_cnt = 0;
      end
      rdy_prev = core_ready;
      cmd_prev = core_initalize || core_compress || core_finalize;
      hs_prev = in_valid && in_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check("idle_before_start", 64'(n < 2000), 64'd1);
    key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [3:0] n, input logic last);
    int t = 0;
    in_data = d;
    in_nbytes = n;
    in_last = last;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 2000);
    check("beat_accepted", 64'(t < 2000), 64'd1);
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 4000);
    check("digest_within_budget", 64'(n < 4000), 64'd1);
    tick();
  endtask

  task automatic msg_empty();
    exp_nonce.push_back(64'h0);
    exp_dig.push_back(DIG_EMPTY);
    do_start(KEY);
    beat(64'h0, 4'd0, 1'b1);
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic msg_15(input logic gap, input logic [7:0] junk);
    exp_nonce.push_back(64'h0706050403020100);
    exp_nonce.push_back(64'h0f0e0d0c0b0a0908);
    exp_dig.push_back(DIG_15);
    do_start(KEY);
    beat(64'h0706050403020100, 4'd8, 1'b0);
    if (gap) begin
      in_valid = 1'b0;
      repeat (3) tick();
    end
    beat({junk, 56'h0e0d0c0b0a0908}, 4'd7, 1'b1);
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic msg_8(input logic [3:0] n);
    exp_nonce.push_back(64'h0706050403020100);
    exp_nonce.push_back(64'h0800000000000000);
    exp_dig.push_back(DIG_8);
    do_start(KEY);
    beat(64'h0706050403020100, n, 1'b1);
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_digest_valid"}, {63'd0, digest_valid}, 64'd0);
    check({tag, "_digest"}, digest, 64'd0);
    check({tag, "_pulses"}, {61'd0, core_initalize, core_compress, core_finalize}, 64'd0);
    check({tag, "_core_key"}, {63'd0, |core_key}, 64'd0);
    check({tag, "_core_nonce"}, core_nonce, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("c_rounds", 64'(core_compression_rounds), 64'd2);
    check("d_rounds", 64'(core_final_rounds), 64'd4);
    reset_n = 1'b1;
    tick();
    // 1: empty message
    msg_empty();
    check("digest_holds", digest, DIG_EMPTY);
    // 2: 15 bytes with an idle gap between beats
    msg_15(1'b1, 8'h00);
    // 3: exactly 8 bytes, then nbytes above 8 clamps to the same result
    msg_8(4'd8);
    msg_8(4'd15);
    // 4: back-to-back beats under random core stalls, garbage in the masked byte
    stall_max = 5;
    msg_15(1'b0, 8'hff);
    check("digest_after_backpressure", digest, DIG_15);
    stall_max = 2;
    // 5: start while busy and start coinciding with digest_valid are both dropped
    begin
      int n = 0;
      exp_nonce.push_back(64'h0);
      exp_dig.push_back(DIG_EMPTY);
      do_start(KEY);
      key = '1;
      start = 1'b1;
      tick();
      start = 1'b0;
      beat(64'h0, 4'd0, 1'b1);
      in_valid = 1'b0;
      while (!digest_valid && n < 4000) begin
        tick();
        n++;
      end
      check("digest_seen", {63'd0, digest_valid}, 64'd1);
      key = '1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_after_dropped_start", {63'd0, busy}, 64'd0);
      check("core_key_kept", core_key[63:0], V0_INIT);
      tick();
      msg_empty();
    end
    // 6: reset while waiting on a compress, then a clean restart
    begin
      int n = 0;
      exp_nonce.push_back(64'h0706050403020100);
      do_start(KEY);
      beat(64'h0706050403020100, 4'd8, 1'b0);
      in_valid = 1'b0;
      while (!core_compress && n < 2000) begin
        tick();
        n++;
      end
      check("compress_seen", {63'd0, core_compress}, 64'd1);
      tick();
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_nonce.delete();
      exp_dig.delete();
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      msg_15(1'b0, 8'h00);
    end
    repeat (5) tick();
    check("digests_left", 64'(exp_dig.size()), 64'd0);
    check("nonces_left", 64'(exp_nonce.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
